// File: rtl/mmu_memory_responder_pkg.sv
// Shared types and constants for the rv32i memory responder: access sizes,
// exception flag positions, bank codes and MMR offsets.
package mmu_memory_responder_pkg;

  typedef enum logic [1:0] {
    MEM_ACCESS_BYTE = 2'd0,
    MEM_ACCESS_HALF = 2'd1,
    MEM_ACCESS_WORD = 2'd2
  } mem_access_t;

  localparam int MEM_EXC_MISALIGNED    = 0;
  localparam int MEM_EXC_ILLEGAL_ADDR  = 1;
  localparam int MEM_EXC_ILLEGAL_WRITE = 2;

  typedef logic [2:0] mem_exception_mask_t;

  localparam logic [3:0] MMU_BANK_INST = 4'h0;
  localparam logic [3:0] MMU_BANK_DATA = 4'h1;
  localparam logic [3:0] MMU_BANK_MMR  = 4'h8;

  localparam logic [27:0] MMR_CYCLES_LO  = 28'h00;
  localparam logic [27:0] MMR_CYCLES_HI  = 28'h04;
  localparam logic [27:0] MMR_LEDS       = 28'h08;
  localparam logic [27:0] MMR_SCRATCH    = 28'h0C;
  localparam logic [27:0] MMR_FAULT_ADDR = 28'h10;
  localparam logic [27:0] MMR_FAULT_CAUSE = 28'h14;

  function automatic logic mmr_is_read_only(input logic [27:0] off);
    return (off == MMR_CYCLES_LO) || (off == MMR_CYCLES_HI) || (off == MMR_FAULT_ADDR);
  endfunction

endpackage

// File: rtl/mmu_memory_responder_lane_align.sv
// Byte-lane steering for RAM accesses: byte enables, misalignment detection,
// store-data replication and load-data extraction (right-aligned, zero-extended).
module mmu_lane_align
  import mmu_memory_responder_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  mem_access_t access,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic        access_ok,
  output logic        misaligned,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_word,
  output logic [31:0] rd_data
);

  logic [31:0] rd_shift;

  always_comb begin
    access_ok  = 1'b1;
    misaligned = 1'b0;
    byte_en    = 4'b0000;
    wr_word    = 32'h0;
    rd_data    = 32'h0;
    rd_shift   = rd_word >> {addr_lo, 3'b000};
    case (access)
      MEM_ACCESS_BYTE: begin
        byte_en = 4'b0001 << addr_lo;
        wr_word = {4{wr_data[7:0]}};
        rd_data = {24'h0, rd_shift[7:0]};
      end
      MEM_ACCESS_HALF: begin
        misaligned = addr_lo[0];
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_word    = {2{wr_data[15:0]}};
        rd_data    = {16'h0, addr_lo[1] ? rd_word[31:16] : rd_word[15:0]};
      end
      MEM_ACCESS_WORD: begin
        misaligned = (addr_lo != 2'b00);
        byte_en    = 4'b1111;
        wr_word    = wr_data;
        rd_data    = rd_word;
      end
      default: access_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/mmu_memory_responder.sv
// Memory responder: decodes addr[31:28] into inst RAM, data RAM and MMRs.
// Optional fault logging (FAULT_ADDR/FAULT_CAUSE) is enabled by defining MMU_FAULT_LOG_EN.
module mmu_memory_responder
  import mmu_memory_responder_pkg::*;
#(
  parameter int    INST_WORDS = 256,
  parameter int    DATA_WORDS = 256,
  parameter string INIT_INST  = "",
  parameter string INIT_DATA  = "",
  parameter int    LED_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wr_data,
  input  logic                mem_wr_ena,
  input  mem_access_t         mem_access,
  output logic [31:0]         mem_rd_data,
  output mem_exception_mask_t mem_exception,
  output logic [LED_W-1:0]    leds
);

  localparam int IAW = (INST_WORDS > 1) ? $clog2(INST_WORDS) : 1;
  localparam int DAW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
  localparam logic [31:0] INST_LIMIT = INST_WORDS;
  localparam logic [31:0] DATA_LIMIT = DATA_WORDS;

  logic [31:0] inst_mem [INST_WORDS];
  logic [31:0] data_mem [DATA_WORDS];

  logic [63:0]      cycles_q;
  logic [LED_W-1:0] leds_q;
  logic [31:0]      scratch_q;
`ifdef MMU_FAULT_LOG_EN
  logic [31:0]         fault_addr_q;
  mem_exception_mask_t fault_cause_q;
`endif

  logic [3:0]  bank;
  logic [25:0] word_idx;
  logic [27:0] mmr_off;
  logic        is_inst, is_data, is_mmr;
  logic        mmr_defined, mmr_ro;
  logic [31:0] ram_word, mmr_word;
  logic        wr_commit, data_we;

  logic        access_ok, lane_misaligned;
  logic [3:0]  byte_en;
  logic [31:0] wr_word, lane_rd;

  assign bank     = mem_addr[31:28];
  assign word_idx = mem_addr[27:2];
  assign mmr_off  = {mem_addr[27:2], 2'b00};
  assign is_inst  = (bank == MMU_BANK_INST);
  assign is_data  = (bank == MMU_BANK_DATA);
  assign is_mmr   = (bank == MMU_BANK_MMR);

  mmu_lane_align u_lane (
    .addr_lo    (mem_addr[1:0]),
    .access     (mem_access),
    .wr_data    (mem_wr_data),
    .rd_word    (ram_word),
    .access_ok  (access_ok),
    .misaligned (lane_misaligned),
    .byte_en    (byte_en),
    .wr_word    (wr_word),
    .rd_data    (lane_rd)
  );

  always_comb begin
    mmr_defined = 1'b0;
    mmr_word    = 32'h0;
    case (mmr_off)
      MMR_CYCLES_LO:   begin mmr_defined = 1'b1; mmr_word = cycles_q[31:0];  end
      MMR_CYCLES_HI:   begin mmr_defined = 1'b1; mmr_word = cycles_q[63:32]; end
      MMR_LEDS:        begin mmr_defined = 1'b1; mmr_word = 32'(leds_q);     end
      MMR_SCRATCH:     begin mmr_defined = 1'b1; mmr_word = scratch_q;       end
`ifdef MMU_FAULT_LOG_EN
      MMR_FAULT_ADDR:  begin mmr_defined = 1'b1; mmr_word = fault_addr_q;         end
      MMR_FAULT_CAUSE: begin mmr_defined = 1'b1; mmr_word = 32'(fault_cause_q);   end
`endif
      default: ;
    endcase
    mmr_ro = mmr_is_read_only(mmr_off);
  end

  always_comb begin
    ram_word = is_inst ? inst_mem[word_idx[IAW-1:0]] : data_mem[word_idx[DAW-1:0]];

    mem_exception = '0;
    // MMRs are word-only, so a sub-word MMR access is reported as misaligned.
    mem_exception[MEM_EXC_MISALIGNED] = access_ok &&
        (lane_misaligned || (is_mmr && (mem_access != MEM_ACCESS_WORD)));
    mem_exception[MEM_EXC_ILLEGAL_ADDR] = !access_ok ||
        !(is_inst || is_data || is_mmr) ||
        (is_inst && ({6'h0, word_idx} >= INST_LIMIT)) ||
        (is_data && ({6'h0, word_idx} >= DATA_LIMIT)) ||
        (is_mmr && !mmr_defined);
    mem_exception[MEM_EXC_ILLEGAL_WRITE] = mem_wr_ena &&
        (is_inst || (is_mmr && mmr_defined && mmr_ro));

    if (mem_exception != '0) mem_rd_data = 32'h0;
    else if (is_mmr)         mem_rd_data = mmr_word;
    else                     mem_rd_data = lane_rd;

    wr_commit = mem_wr_ena && (mem_exception == '0);
    data_we   = wr_commit && is_data && rst_n;
  end

  always_ff @(posedge clk) begin
    if (data_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) data_mem[word_idx[DAW-1:0]][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_q  <= 64'h0;
      leds_q    <= '0;
      scratch_q <= 32'h0;
`ifdef MMU_FAULT_LOG_EN
      fault_addr_q  <= 32'h0;
      fault_cause_q <= '0;
`endif
    end else begin
      cycles_q <= cycles_q + 64'h1;
      if (wr_commit && is_mmr && (mmr_off == MMR_LEDS))    leds_q    <= mem_wr_data[LED_W-1:0];
      if (wr_commit && is_mmr && (mmr_off == MMR_SCRATCH)) scratch_q <= mem_wr_data;
`ifdef MMU_FAULT_LOG_EN
      // First faulting store sticks until software clears the cause bits.
      if (mem_wr_ena && (mem_exception != '0) && (fault_cause_q == '0)) begin
        fault_addr_q  <= mem_addr;
        fault_cause_q <= mem_exception;
      end else if (wr_commit && is_mmr && (mmr_off == MMR_FAULT_CAUSE)) begin
        fault_cause_q <= fault_cause_q & ~mem_wr_data[2:0];
      end
`endif
    end
  end

  assign leds = leds_q;

endmodule

// File: tb/tb_mmu_memory_responder.sv
// Directed self-checking bench for mmu_memory_responder (default build; the
// fault-log checks run only when MMU_FAULT_LOG_EN is defined).
module tb_mmu_memory_responder;
  import mmu_memory_responder_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [31:0]         mem_addr;
  logic [31:0]         mem_wr_data;
  logic                mem_wr_ena;
  mem_access_t         mem_access;
  logic [31:0]         mem_rd_data;
  mem_exception_mask_t mem_exception;
  logic [7:0]          leds;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [2:0] E_NONE = 3'b000;
  localparam logic [2:0] E_MIS  = 3'b001;
  localparam logic [2:0] E_ADDR = 3'b010;
  localparam logic [2:0] E_WR   = 3'b100;

  mmu_memory_responder #(
    .INST_WORDS(256), .DATA_WORDS(256), .INIT_INST(""), .INIT_DATA(""), .LED_W(8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_ena    (mem_wr_ena),
    .mem_access    (mem_access),
    .mem_rd_data   (mem_rd_data),
    .mem_exception (mem_exception),
    .leds          (leds)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic rd_check(input string tag, input logic [31:0] a, input mem_access_t acc,
                          input logic [31:0] exp_d, input logic [2:0] exp_e);
    @(negedge clk);
    mem_addr = a; mem_access = acc; mem_wr_ena = 1'b0; mem_wr_data = 32'h0;
    #1;
    check({tag, "_data"}, mem_rd_data, exp_d);
    check({tag, "_exc"}, {29'h0, mem_exception}, {29'h0, exp_e});
  endtask

  task automatic wr_check(input string tag, input logic [31:0] a, input mem_access_t acc,
                          input logic [31:0] d, input logic [2:0] exp_e);
    @(negedge clk);
    mem_addr = a; mem_access = acc; mem_wr_data = d; mem_wr_ena = 1'b1;
    #1;
    check({tag, "_exc"}, {29'h0, mem_exception}, {29'h0, exp_e});
    @(negedge clk);
    mem_wr_ena = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    mem_addr = 32'h0; mem_wr_data = 32'h0; mem_wr_ena = 1'b0; mem_access = MEM_ACCESS_WORD;
    dut.inst_mem[0] = 32'h0050_0093;
    #1;
    // reset state, read combinationally while reset is held
    check("rst_leds", {24'h0, leds}, 32'h0);
    mem_addr = 32'h8000_0000;
    #1;
    check("rst_cycles_lo", mem_rd_data, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: instruction fetch and sub-word loads from inst RAM
    rd_check("inst0_word", 32'h0000_0000, MEM_ACCESS_WORD, 32'h0050_0093, E_NONE);
    rd_check("inst0_byte0", 32'h0000_0000, MEM_ACCESS_BYTE, 32'h0000_0093, E_NONE);
    rd_check("inst0_half2", 32'h0000_0002, MEM_ACCESS_HALF, 32'h0000_0050, E_NONE);

    // 2: lane-merged stores into data RAM
    wr_check("st_w4", 32'h1000_0004, MEM_ACCESS_WORD, 32'hDEAD_BEEF, E_NONE);
    wr_check("st_b6", 32'h1000_0006, MEM_ACCESS_BYTE, 32'h0000_0011, E_NONE);
    rd_check("ld_w4", 32'h1000_0004, MEM_ACCESS_WORD, 32'hDE11_BEEF, E_NONE);
    rd_check("ld_h6", 32'h1000_0006, MEM_ACCESS_HALF, 32'h0000_DE11, E_NONE);
    rd_check("ld_h4", 32'h1000_0004, MEM_ACCESS_HALF, 32'h0000_BEEF, E_NONE);
    rd_check("ld_b7", 32'h1000_0007, MEM_ACCESS_BYTE, 32'h0000_00DE, E_NONE);
    wr_check("st_w8", 32'h1000_0008, MEM_ACCESS_WORD, 32'h0000_0000, E_NONE);
    wr_check("st_h10", 32'h1000_000A, MEM_ACCESS_HALF, 32'hFFFF_1234, E_NONE);
    rd_check("ld_w8", 32'h1000_0008, MEM_ACCESS_WORD, 32'h1234_0000, E_NONE);

    // 3: misaligned accesses
    wr_check("st_w0", 32'h1000_0000, MEM_ACCESS_WORD, 32'h0123_4567, E_NONE);
    rd_check("mis_ld_w2", 32'h1000_0002, MEM_ACCESS_WORD, 32'h0, E_MIS);
    rd_check("mis_ld_h5", 32'h1000_0005, MEM_ACCESS_HALF, 32'h0, E_MIS);
    wr_check("mis_st_w3", 32'h1000_0003, MEM_ACCESS_WORD, 32'hFFFF_FFFF, E_MIS);
    rd_check("after_mis_w0", 32'h1000_0000, MEM_ACCESS_WORD, 32'h0123_4567, E_NONE);

    // 4: illegal writes and addresses
    wr_check("st_inst0", 32'h0000_0000, MEM_ACCESS_WORD, 32'hFFFF_FFFF, E_WR);
    rd_check("inst0_kept", 32'h0000_0000, MEM_ACCESS_WORD, 32'h0050_0093, E_NONE);
    rd_check("data_oob", 32'h1000_0400, MEM_ACCESS_WORD, 32'h0, E_ADDR);
    rd_check("bank_bad", 32'h2000_0000, MEM_ACCESS_WORD, 32'h0, E_ADDR);
    rd_check("acc_bad", 32'h1000_0004, mem_access_t'(2'b11), 32'h0, E_ADDR);

    // MMR decode
    wr_check("st_scratch", 32'h8000_000C, MEM_ACCESS_WORD, 32'hCAFE_F00D, E_NONE);
    rd_check("ld_scratch", 32'h8000_000C, MEM_ACCESS_WORD, 32'hCAFE_F00D, E_NONE);
    wr_check("st_cyc_ro", 32'h8000_0000, MEM_ACCESS_WORD, 32'h0, E_WR);
    rd_check("mmr_byte", 32'h8000_0008, MEM_ACCESS_BYTE, 32'h0, E_MIS);
    rd_check("mmr_mis", 32'h8000_0009, MEM_ACCESS_WORD, 32'h0, E_MIS);
    rd_check("mmr_undef", 32'h8000_0018, MEM_ACCESS_WORD, 32'h0, E_ADDR);

    // 5: cycle counter from reset release, LEDs, asynchronous reset
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    mem_addr = 32'h8000_0000; mem_access = MEM_ACCESS_WORD; mem_wr_ena = 1'b0;
    #1;
    check("cycles_lo_10", mem_rd_data, 32'd10);
    mem_addr = 32'h8000_0004;
    #1;
    check("cycles_hi_0", mem_rd_data, 32'h0);
    rd_check("scratch_rst", 32'h8000_000C, MEM_ACCESS_WORD, 32'h0, E_NONE);
    wr_check("st_leds", 32'h8000_0008, MEM_ACCESS_WORD, 32'hFFFF_FFA5, E_NONE);
    check("leds_a5", {24'h0, leds}, 32'h0000_00A5);
    rd_check("ld_leds", 32'h8000_0008, MEM_ACCESS_WORD, 32'h0000_00A5, E_NONE);

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    mem_addr = 32'h8000_0000;
    #1;
    check("async_leds", {24'h0, leds}, 32'h0);
    check("async_cycles", mem_rd_data, 32'h0);

    // store attempted while reset is held must be lost
    wr_check("st_in_rst", 32'h1000_0004, MEM_ACCESS_WORD, 32'h5555_5555, E_NONE);
    @(negedge clk); rst_n = 1'b1;
    rd_check("rst_blocks_wr", 32'h1000_0004, MEM_ACCESS_WORD, 32'hDE11_BEEF, E_NONE);

`ifdef MMU_FAULT_LOG_EN
    // 6: first faulting store is logged, cause cleared by write-one
    wr_check("flt_st1", 32'h0000_0004, MEM_ACCESS_WORD, 32'h1, E_WR);
    wr_check("flt_st2", 32'h0000_0008, MEM_ACCESS_WORD, 32'h2, E_WR);
    rd_check("flt_addr", 32'h8000_0010, MEM_ACCESS_WORD, 32'h0000_0004, E_NONE);
    rd_check("flt_cause", 32'h8000_0014, MEM_ACCESS_WORD, 32'h0000_0004, E_NONE);
    wr_check("flt_clr", 32'h8000_0014, MEM_ACCESS_WORD, 32'h0000_0004, E_NONE);
    rd_check("flt_cause_clr", 32'h8000_0014, MEM_ACCESS_WORD, 32'h0, E_NONE);
`else
    rd_check("flt_addr_off", 32'h8000_0010, MEM_ACCESS_WORD, 32'h0, E_ADDR);
    rd_check("flt_cause_off", 32'h8000_0014, MEM_ACCESS_WORD, 32'h0, E_ADDR);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
